// File: rtl/cache_control_4way_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_control_4way_pkg
// Purpose  : Shared types, constants and helpers for the 4-way cache
//            control FSM and its datapath/LRU hookup.
// Revision : 1.0  initial release
// ============================================================================
package cache_control_4way_pkg;

  typedef logic [1:0] lc3b_2bit;
  typedef logic [3:0] lc3b_4bit;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_ctrl_state_t;

  // Data array write source
  localparam logic DATA_SRC_CPU     = 1'b0;
  localparam logic DATA_SRC_PMEM    = 1'b1;

  // Physical-memory address source
  localparam logic PMEM_ADDR_CPU    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  // Way index to one-hot MRU strobe
  function automatic lc3b_4bit way_onehot(input lc3b_2bit idx);
    return lc3b_4bit'(1) << idx;
  endfunction

  // Increment that sticks at full scale instead of wrapping
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == c_cnt_max) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_control_4way_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_control_4way_if
// Purpose  : Bundles the CPU, datapath, LRU and physical-memory signals seen
//            by the cache control FSM. slave = controller view,
//            master = environment (CPU/datapath/pmem) view.
// Revision : 1.0  initial release
// ============================================================================
interface cache_control_4way_if;
  import cache_control_4way_pkg::*;

  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  lc3b_4bit    hit_way;
  lc3b_2bit    replace_way;
  logic        victim_dirty;
  logic        pmem_resp;
  logic        pmem_read;
  logic        pmem_write;
  lc3b_4bit    lru_update;
  lc3b_2bit    way_sel;
  logic        load_data;
  logic        load_tag;
  logic        set_dirty;
  logic        data_src;
  logic        addr_sel;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  mem_read, mem_write, hit_way, replace_way, victim_dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, lru_update, way_sel, load_data,
           load_tag, set_dirty, data_src, addr_sel, hit_count, miss_count
  );

  modport master (
    output mem_read, mem_write, hit_way, replace_way, victim_dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, lru_update, way_sel, load_data,
           load_tag, set_dirty, data_src, addr_sel, hit_count, miss_count
  );

endinterface
`default_nettype wire

// File: rtl/way_encoder.sv
`default_nettype none
// ============================================================================
// Module   : way_encoder
// Purpose  : 4-bit hit vector to 2-bit way index. Lowest set bit wins when
//            more than one way reports a match; o_valid flags any match.
// Revision : 1.0  initial release
// ============================================================================
module way_encoder
  import cache_control_4way_pkg::*;
(
  input  lc3b_4bit i_onehot,
  output lc3b_2bit o_index,
  output logic     o_valid
);

  // Priority encode, lowest index first
  always_comb begin
    o_valid = |i_onehot;
    if (i_onehot[0])      o_index = 2'd0;
    else if (i_onehot[1]) o_index = 2'd1;
    else if (i_onehot[2]) o_index = 2'd2;
    else if (i_onehot[3]) o_index = 2'd3;
    else                  o_index = 2'd0;
  end

endmodule
`default_nettype wire

// File: rtl/cache_control_4way.sv
`default_nettype none
// ============================================================================
// Module   : cache_control_4way
// Purpose  : Control FSM for the 4-way set-associative L1 cache. Serves hits,
//            writes back dirty victims, fills lines, strobes the pseudo-LRU
//            array and keeps saturating hit/miss counters.
// Revision : 1.0  initial release
// ============================================================================
module cache_control_4way
  import cache_control_4way_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  cache_control_4way_if.slave  bus
);

  cache_ctrl_state_t r_state;
  cache_ctrl_state_t w_next_state;
  lc3b_2bit          r_victim;
  logic              r_retry;
  logic [15:0]       r_hit_count;
  logic [15:0]       r_miss_count;

  logic     w_req;
  logic     w_write;
  logic     w_hit;
  lc3b_2bit w_hit_idx;
  logic     w_idle_hit;
  logic     w_idle_miss;

  logic     w_mem_resp;
  logic     w_pmem_read;
  logic     w_pmem_write;
  lc3b_4bit w_lru_update;
  lc3b_2bit w_way_sel;
  logic     w_load_data;
  logic     w_load_tag;
  logic     w_set_dirty;
  logic     w_data_src;
  logic     w_addr_sel;

  // A simultaneous read and write is handled as a write
  assign w_req       = bus.mem_read | bus.mem_write;
  assign w_write     = bus.mem_write;
  assign w_idle_hit  = (r_state == IDLE) && w_req && w_hit;
  assign w_idle_miss = (r_state == IDLE) && w_req && !w_hit;

  way_encoder u_way_encoder (
    .i_onehot (bus.hit_way),
    .o_index  (w_hit_idx),
    .o_valid  (w_hit)
  );

  // Next state and Mealy outputs; everything forced quiet while reset is high
  always_comb begin
    w_next_state = r_state;
    w_mem_resp   = 1'b0;
    w_pmem_read  = 1'b0;
    w_pmem_write = 1'b0;
    w_lru_update = '0;
    w_way_sel    = '0;
    w_load_data  = 1'b0;
    w_load_tag   = 1'b0;
    w_set_dirty  = 1'b0;
    w_data_src   = DATA_SRC_CPU;
    w_addr_sel   = PMEM_ADDR_CPU;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              w_mem_resp   = 1'b1;
              w_way_sel    = w_hit_idx;
              w_lru_update = way_onehot(w_hit_idx);
              if (w_write) begin
                w_load_data = 1'b1;
                w_set_dirty = 1'b1;
                w_data_src  = DATA_SRC_CPU;
              end
            end else begin
              // Point the datapath at the victim now so its dirty bit is
              // available to pick the next state in this same cycle
              w_way_sel    = bus.replace_way;
              w_next_state = bus.victim_dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          w_pmem_write = 1'b1;
          w_addr_sel   = PMEM_ADDR_VICTIM;
          w_way_sel    = r_victim;
          if (bus.pmem_resp) w_next_state = ALLOCATE;
        end
        ALLOCATE: begin
          w_pmem_read = 1'b1;
          w_addr_sel  = PMEM_ADDR_CPU;
          w_way_sel   = r_victim;
          if (bus.pmem_resp) begin
            w_load_data  = 1'b1;
            w_load_tag   = 1'b1;
            w_data_src   = DATA_SRC_PMEM;
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State, latched victim, retry flag and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_victim     <= '0;
      r_retry      <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_idle_miss) begin
        r_victim     <= bus.replace_way;
        r_retry      <= 1'b1;
        r_miss_count <= sat_inc(r_miss_count);
      end
      // Only a hit on the first attempt counts; the re-serviced hit after
      // a fill just clears the retry flag
      if (w_idle_hit) begin
        r_retry <= 1'b0;
        if (!r_retry) r_hit_count <= sat_inc(r_hit_count);
      end
    end
  end

  assign bus.mem_resp   = w_mem_resp;
  assign bus.pmem_read  = w_pmem_read;
  assign bus.pmem_write = w_pmem_write;
  assign bus.lru_update = w_lru_update;
  assign bus.way_sel    = w_way_sel;
  assign bus.load_data  = w_load_data;
  assign bus.load_tag   = w_load_tag;
  assign bus.set_dirty  = w_set_dirty;
  assign bus.data_src   = w_data_src;
  assign bus.addr_sel   = w_addr_sel;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_control_4way.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_control_4way
// Purpose  : Bench for cache_control_4way. Directed checks of reset, hits,
//            clean/dirty misses, reset mid-fill and counter saturation, then a
//            randomized phase checked by a scoreboard fed from a
//            transaction-level cache model (tags, dirty bits, true LRU order).
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_control_4way;
  import cache_control_4way_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_control_4way_if bus ();

  cache_control_4way dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] ctl_vec();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.lru_update, bus.way_sel,
            bus.load_data, bus.load_tag, bus.set_dirty, bus.data_src, bus.addr_sel};
  endfunction

  // LRU order packed as four 2-bit way ids, [1:0] = least recently used
  function automatic logic [7:0] lru_touch(input logic [7:0] ord, input logic [1:0] w);
    logic [1:0] q[$];
    logic [7:0] r;
    for (int i = 0; i < 4; i++) if (ord[2*i +: 2] != w) q.push_back(ord[2*i +: 2]);
    q.push_back(w);
    for (int i = 0; i < 4; i++) r[2*i +: 2] = q[i];
    return r;
  endfunction

  // ---------------- environment: datapath tag/dirty store and LRU array ----
  logic [7:0] env_tag [4];
  logic [3:0] env_valid, env_dirty, w_env_hit;
  logic [7:0] env_order;
  logic [7:0] cur_tag;
  logic       ovr_en;
  logic [3:0] ovr_hit;
  logic [1:0] ovr_rep;
  logic       ovr_dirty;
  bit         resp_en = 0;

  always_comb begin
    w_env_hit = '0;
    for (int w = 0; w < 4; w++) w_env_hit[w] = env_valid[w] && (env_tag[w] == cur_tag);
  end

  assign bus.hit_way      = ovr_en ? ovr_hit   : w_env_hit;
  assign bus.replace_way  = ovr_en ? ovr_rep   : env_order[1:0];
  assign bus.victim_dirty = ovr_en ? ovr_dirty : env_dirty[bus.way_sel];

  always @(posedge clk) begin
    if (reset) begin
      env_valid <= '0;
      env_dirty <= '0;
      env_order <= 8'hE4;
      for (int w = 0; w < 4; w++) env_tag[w] <= '0;
    end else begin
      if (bus.load_tag) begin
        env_tag[bus.way_sel]   <= cur_tag;
        env_valid[bus.way_sel] <= 1'b1;
        env_dirty[bus.way_sel] <= 1'b0;
      end else if (bus.set_dirty) begin
        env_dirty[bus.way_sel] <= 1'b1;
      end
      case (bus.lru_update)
        4'b0001: env_order <= lru_touch(env_order, 2'd0);
        4'b0010: env_order <= lru_touch(env_order, 2'd1);
        4'b0100: env_order <= lru_touch(env_order, 2'd2);
        4'b1000: env_order <= lru_touch(env_order, 2'd3);
        default: ;
      endcase
    end
  end

  // Physical memory: random latency, one-cycle done pulse
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (bus.pmem_resp) begin
          bus.pmem_resp = 1'b0;
          lat = $urandom_range(0, 4);
        end else if (bus.pmem_read || bus.pmem_write) begin
          if (lat == 0) bus.pmem_resp = 1'b1;
          else lat--;
        end
      end
    end
  end

  // ---------------- reference model and scoreboard -------------------------
  typedef struct packed { logic [1:0] way; logic wr; logic [15:0] hc; logic [15:0] mc; } resp_t;
  typedef struct packed { logic [1:0] way; logic wb; logic [15:0] mc; } fill_t;
  resp_t rq[$];
  fill_t fq[$];
  bit    sb_en = 0;

  logic [7:0]  rtag [4];
  logic [3:0]  rvalid, rdirty;
  logic [7:0]  rorder;
  logic        rretry;
  logic [15:0] rhc, rmc;

  task automatic ref_reset();
    rvalid = '0; rdirty = '0; rorder = 8'hE4; rretry = 1'b0; rhc = '0; rmc = '0;
    for (int w = 0; w < 4; w++) rtag[w] = '0;
  endtask

  // Monitor: invariants every cycle, scoreboard pops on resp and fill
  initial begin
    logic  prev_pr, prev_pw, prev_resp, cnt_pend, saw_wb;
    resp_t pend, r;
    fill_t f;
    prev_pr = 0; prev_pw = 0; prev_resp = 0; cnt_pend = 0; saw_wb = 0;
    forever begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write)
        check("pmem_rd_wr_exclusive", {bus.pmem_read, bus.pmem_write} == 2'b11, 0);
      if (bus.lru_update != 0)
        check("lru_onehot_on_resp", {bus.mem_resp, $countones(bus.lru_update) == 1}, 2'b11);
      if (!reset && prev_pr && !prev_resp) check("pmem_read_held", bus.pmem_read, 1);
      if (!reset && prev_pw && !prev_resp) check("pmem_write_held", bus.pmem_write, 1);
      prev_pr = bus.pmem_read; prev_pw = bus.pmem_write; prev_resp = bus.pmem_resp;
      if (sb_en) begin
        if (cnt_pend) begin
          check("sb_hit_count", bus.hit_count, pend.hc);
          check("sb_miss_count", bus.miss_count, pend.mc);
          cnt_pend = 0;
        end
        if (bus.pmem_write) begin
          check("wb_addr_sel", bus.addr_sel, 1);
          saw_wb = 1;
        end
        if (bus.pmem_read) check("fill_addr_sel", bus.addr_sel, 0);
        if (bus.load_tag) begin
          if (fq.size() == 0) check("fill_unexpected", 1, 0);
          else begin
            f = fq.pop_front();
            check("fill_way", bus.way_sel, f.way);
            check("fill_ctl", {bus.load_data, bus.data_src, bus.pmem_read, bus.pmem_resp}, 4'b1111);
            check("fill_writeback_seen", saw_wb, f.wb);
            check("fill_miss_count", bus.miss_count, f.mc);
          end
          saw_wb = 0;
        end
        if (bus.mem_resp) begin
          if (rq.size() == 0) check("resp_unexpected", 1, 0);
          else begin
            r = rq.pop_front();
            check("resp_way", bus.way_sel, r.way);
            check("resp_lru", bus.lru_update, way_onehot(r.way));
            check("resp_wr_ctl", {bus.load_data, bus.set_dirty, bus.data_src, bus.load_tag},
                  {r.wr, r.wr, 2'b00});
            pend = r;
            cnt_pend = 1;
          end
        end
      end
    end
  end

  // One random CPU access; mode 0 read, 1 write, 2 both
  task automatic run_txn(input logic [7:0] tag, input int mode, input bit drop);
    bit hit, wr, done;
    logic [1:0] hw, v;
    @(posedge clk); #1;
    cur_tag = tag;
    bus.mem_read  = (mode != 1);
    bus.mem_write = (mode != 0);
    wr  = (mode != 0);
    hit = 0; hw = 0;
    for (int w = 0; w < 4; w++)
      if (!hit && rvalid[w] && rtag[w] == tag) begin hit = 1; hw = w[1:0]; end
    v = rorder[1:0];
    if (hit) begin
      if (wr) rdirty[hw] = 1'b1;
      rorder = lru_touch(rorder, hw);
      if (!rretry) rhc = sat_inc(rhc);
      rretry = 1'b0;
      rq.push_back('{hw, wr, rhc, rmc});
    end else begin
      rmc = sat_inc(rmc);
      rretry = 1'b1;
      fq.push_back('{v, rdirty[v], rmc});
      rtag[v] = tag; rvalid[v] = 1'b1; rdirty[v] = 1'b0;
      if (!drop) begin
        if (wr) rdirty[v] = 1'b1;
        rorder = lru_touch(rorder, v);
        rretry = 1'b0;
        rq.push_back('{v, wr, rhc, rmc});
      end
    end
    @(negedge clk);
    if (hit) check("hit_latency", bus.mem_resp, 1);
    else     check("miss_detect", {bus.mem_resp, bus.way_sel}, {1'b0, v});
    if (!hit) begin
      if (drop) begin
        @(posedge clk); #1;
        bus.mem_read = 0; bus.mem_write = 0;
      end
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        @(negedge clk);
        done = drop ? bus.load_tag : bus.mem_resp;
      end
      if (!done) check("txn_timeout", 0, 1);
    end
    if ($urandom_range(0, 1) == 1) begin
      @(posedge clk); #1;
      bus.mem_read = 0; bus.mem_write = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  // Directed miss body: n cycles in the current pmem state, done on the last
  task automatic pmem_phase(input int n, input bit is_wr, input logic [1:0] way, input string nm);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.pmem_resp = (i == n - 1);
      @(negedge clk);
      check({nm, "_req"}, {bus.pmem_read, bus.pmem_write, bus.addr_sel, bus.way_sel},
            {!is_wr, is_wr, is_wr, way});
      check({nm, "_load_tag"}, bus.load_tag, (!is_wr && i == n - 1));
    end
    @(posedge clk); #1;
    bus.pmem_resp = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0; cur_tag = 0;
    ovr_en = 1; ovr_hit = 4'b0100; ovr_rep = 0; ovr_dirty = 0;
    ref_reset();

    // Reset: outputs quiet even with a request present
    bus.mem_read = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", ctl_vec(), 0);
    check("reset_counters", {bus.hit_count, bus.miss_count}, 0);

    // Read hit way 2
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("rd_hit", {bus.mem_resp, bus.lru_update, bus.way_sel, bus.load_data},
          {1'b1, 4'b0100, 2'd2, 1'b0});
    @(posedge clk); #1; bus.mem_read = 0;
    @(negedge clk);
    check("rd_hit_count", {bus.hit_count, bus.miss_count, bus.mem_resp}, {16'd1, 16'd0, 1'b0});

    // Write hit way 0
    @(posedge clk); #1; bus.mem_write = 1; ovr_hit = 4'b0001;
    @(negedge clk);
    check("wr_hit", {bus.mem_resp, bus.load_data, bus.set_dirty, bus.data_src, bus.lru_update, bus.way_sel},
          {4'b1110, 4'b0001, 2'd0});
    // Multi-hot hit: lowest way wins
    @(posedge clk); #1; bus.mem_write = 0; bus.mem_read = 1; ovr_hit = 4'b1010;
    @(negedge clk);
    check("multihot_hit", {bus.lru_update, bus.way_sel}, {4'b0010, 2'd1});
    check("hit_count_after_wr", bus.hit_count, 2);

    // Clean miss into way 3, five ALLOCATE cycles
    @(posedge clk); #1; ovr_hit = 4'b0000; ovr_rep = 3; ovr_dirty = 0;
    @(negedge clk);
    check("clean_miss_detect", {bus.mem_resp, bus.way_sel, bus.pmem_read}, {1'b0, 2'd3, 1'b0});
    pmem_phase(5, 0, 2'd3, "clean_alloc");
    ovr_hit = 4'b1000;
    @(negedge clk);
    check("clean_miss_rehit", {bus.mem_resp, bus.lru_update, bus.way_sel}, {1'b1, 4'b1000, 2'd3});
    check("clean_miss_counts", {bus.hit_count, bus.miss_count}, {16'd3, 16'd1});
    @(posedge clk); #1; bus.mem_read = 0;
    @(negedge clk);
    check("rehit_not_counted", {bus.hit_count, bus.miss_count}, {16'd3, 16'd1});

    // Dirty miss into way 1: writeback then fill
    @(posedge clk); #1; bus.mem_write = 1; ovr_hit = 0; ovr_rep = 1; ovr_dirty = 1;
    @(negedge clk);
    check("dirty_miss_detect", {bus.way_sel, bus.pmem_write}, {2'd1, 1'b0});
    pmem_phase(3, 1, 2'd1, "dirty_wb");
    pmem_phase(2, 0, 2'd1, "dirty_alloc");
    ovr_hit = 4'b0010;
    @(negedge clk);
    check("dirty_miss_rehit", {bus.mem_resp, bus.load_data, bus.set_dirty, bus.way_sel},
          {3'b111, 2'd1});
    @(posedge clk); #1; bus.mem_write = 0;
    @(negedge clk);
    check("dirty_miss_counts", {bus.hit_count, bus.miss_count}, {16'd3, 16'd2});

    // Reset in the middle of ALLOCATE
    @(posedge clk); #1; bus.mem_read = 1; ovr_hit = 0; ovr_rep = 2; ovr_dirty = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("alloc_before_reset", bus.pmem_read, 1);
    @(posedge clk); #1; reset = 1; bus.mem_read = 0;
    @(negedge clk);
    check("alloc_during_reset", ctl_vec(), 0);
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("after_reset_idle", ctl_vec(), 0);
    check("after_reset_counters", {bus.hit_count, bus.miss_count}, 0);
    @(posedge clk); #1; bus.mem_read = 1; ovr_hit = 4'b0001;
    @(negedge clk);
    check("after_reset_hit", {bus.mem_resp, bus.load_tag}, 2'b10);
    @(posedge clk); #1; bus.mem_read = 0;
    @(negedge clk);
    check("after_reset_hit_count", bus.hit_count, 1);

    // Randomized phase against the reference model
    @(posedge clk); #1; reset = 1; ovr_en = 0;
    @(posedge clk); #1; reset = 0; ref_reset(); resp_en = 1; sb_en = 1;
    for (int t = 0; t < 400; t++) begin
      logic [7:0] tg;
      int md;
      bit dr;
      tg = 8'($urandom_range(0, 5));
      md = $urandom_range(0, 2);
      dr = ($urandom_range(0, 9) == 0);
      run_txn(tg, md, dr);
    end
    @(posedge clk); #1; bus.mem_read = 0; bus.mem_write = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", rq.size() + fq.size(), 0);
    sb_en = 0; resp_en = 0;

    // Hit counter saturation
    @(posedge clk); #1; reset = 1; ovr_en = 1; ovr_hit = 4'b0001; bus.mem_read = 1;
    @(posedge clk); #1; reset = 0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("hit_count_fffe", bus.hit_count, 16'hFFFE);
    @(posedge clk);
    @(negedge clk);
    check("hit_count_ffff", bus.hit_count, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hit_count_saturated", {bus.hit_count, bus.miss_count}, {16'hFFFF, 16'd0});
    @(posedge clk); #1; bus.mem_read = 0;
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
